// File: rtl/monitor_cmd_engine.sv
// monitor_cmd_engine: UART command engine that lets a controller write or read a bank of byte-wide command registers
// Ports: clk50 sole clock, reset_n synchronous active-low reset;
//   rx_valid/rx_byte/rx_error from the UART receiver, tx_ready/tx_write/tx_byte to the UART transmitter;
//   uart_rts (in) / uart_cts (out) active-low flow control;
//   state/cmd_rw/cmd_id/data_size/busy/err_flag status outputs;
//   reg_wr/reg_sel/reg_idx/reg_wdata/reg_rdata register-bank port (reg_rdata is combinational from sel/idx).
// Build option: define MONITOR_CHECKSUM_EN to add an XOR checksum byte after every payload in both directions.
module monitor_cmd_engine #(
  parameter int NUM_CMDS = 16,
  parameter int MAX_BYTES = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int SW = NUM_CMDS > 1 ? $clog2(NUM_CMDS) : 1,
  localparam int IW = MAX_BYTES > 1 ? $clog2(MAX_BYTES) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          clk50,
  input  logic          reset_n,
  input  logic          rx_valid,
  input  logic [7:0]    rx_byte,
  input  logic          rx_error,
  input  logic          tx_ready,
  output logic          tx_write,
  output logic [7:0]    tx_byte,
  input  logic          uart_rts,
  output logic          uart_cts,
  output logic [2:0]    state,
  output logic          cmd_rw,
  output logic [6:0]    cmd_id,
  output logic [7:0]    data_size,
  output logic          reg_wr,
  output logic [SW-1:0] reg_sel,
  output logic [IW-1:0] reg_idx,
  output logic [7:0]    reg_wdata,
  input  logic [7:0]    reg_rdata,
  output logic          busy,
  output logic          err_flag
);
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    READ_CMD   = 3'd1,
    DATA_BYTES = 3'd2,
    WRITE      = 3'd3,
    READ       = 3'd4,
    RESP       = 3'd5,
    ERROR      = 3'd6
  } state_t;
  state_t state_q, state_d;
  logic cts_q, cts_d, busy_q, busy_d, err_q, err_d;
  logic tx_write_q, tx_write_d, cmd_rw_q, cmd_rw_d;
  logic [7:0] tx_byte_q, tx_byte_d, data_size_q, data_size_d, cnt_q, cnt_d;
  logic [6:0] cmd_id_q, cmd_id_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic timed;
`ifdef MONITOR_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign state = state_q;
  assign uart_cts = cts_q;
  assign busy = busy_q;
  assign err_flag = err_q;
  assign tx_write = tx_write_q;
  assign tx_byte = tx_byte_q;
  assign cmd_rw = cmd_rw_q;
  assign cmd_id = cmd_id_q;
  assign data_size = data_size_q;
  assign reg_sel = cmd_id_q[SW-1:0];
  assign reg_idx = cnt_q[IW-1:0];
  assign reg_wdata = rx_byte;
  always_comb begin
    timed = state_q inside {READ_CMD, DATA_BYTES, WRITE};
    state_d = state_q;
    err_d = err_q;
    tx_write_d = 1'b0;
    tx_byte_d = tx_byte_q;
    cmd_rw_d = cmd_rw_q;
    cmd_id_d = cmd_id_q;
    data_size_d = data_size_q;
    cnt_d = cnt_q;
    reg_wr = 1'b0;
`ifdef MONITOR_CHECKSUM_EN
    csum_d = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (!uart_rts) begin
          state_d = READ_CMD;
          err_d = 1'b0;
        end
      end
      READ_CMD: begin
        if (rx_valid && !rx_error) begin
          cmd_rw_d = rx_byte[7];
          cmd_id_d = rx_byte[6:0];
          state_d = 32'(rx_byte[6:0]) >= NUM_CMDS ? ERROR : DATA_BYTES;
        end
      end
      DATA_BYTES: begin
        if (rx_valid && !rx_error) begin
          data_size_d = rx_byte;
          cnt_d = '0;
`ifdef MONITOR_CHECKSUM_EN
          // size 0 still exchanges the checksum byte, so it takes the normal payload path
          csum_d = '0;
          state_d = 32'(rx_byte) > MAX_BYTES ? ERROR : cmd_rw_q ? WRITE : READ;
`else
          state_d = 32'(rx_byte) > MAX_BYTES ? ERROR : rx_byte == 8'd0 ? RESP : cmd_rw_q ? WRITE : READ;
`endif
        end
      end
      WRITE: begin
        if (rx_valid && !rx_error) begin
          cnt_d = cnt_q + 8'd1;
`ifdef MONITOR_CHECKSUM_EN
          if (cnt_q == data_size_q) state_d = rx_byte == csum_q ? RESP : ERROR;
          else begin
            reg_wr = 1'b1;
            csum_d = csum_q ^ rx_byte;
          end
`else
          reg_wr = 1'b1;
          state_d = 8'(cnt_q + 8'd1) == data_size_q ? RESP : WRITE;
`endif
        end
      end
      READ: begin
        // one idle cycle between launches so the transmitter can drop tx_ready
        if (tx_ready && !tx_write_q) begin
          tx_write_d = 1'b1;
          cnt_d = cnt_q + 8'd1;
`ifdef MONITOR_CHECKSUM_EN
          tx_byte_d = cnt_q == data_size_q ? csum_q : reg_rdata;
          csum_d = csum_q ^ reg_rdata;
          state_d = cnt_q == data_size_q ? IDLE : READ;
`else
          tx_byte_d = reg_rdata;
          state_d = 8'(cnt_q + 8'd1) == data_size_q ? IDLE : READ;
`endif
        end
      end
      RESP: begin
        if (tx_ready) begin
          tx_write_d = 1'b1;
          tx_byte_d = 8'h06;
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (tx_ready) begin
          tx_write_d = 1'b1;
          tx_byte_d = 8'h15;
          err_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // a receive error overrides any byte accepted in the same cycle
    if (timed && rx_error) state_d = ERROR;
    else if (timed && !rx_valid && tmr_q == TW'(TIMEOUT_CYCLES - 1)) state_d = ERROR;
    tmr_d = (!timed || rx_valid || state_d != state_q) ? '0 : tmr_q + 1'b1;
    cts_d = !(state_d inside {READ_CMD, DATA_BYTES, WRITE});
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cts_q <= 1'b1;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      tx_write_q <= 1'b0;
      tx_byte_q <= 8'h00;
      cmd_rw_q <= 1'b0;
      cmd_id_q <= 7'h7F;
      data_size_q <= 8'h00;
      cnt_q <= 8'h00;
      tmr_q <= '0;
`ifdef MONITOR_CHECKSUM_EN
      csum_q <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      cts_q <= cts_d;
      busy_q <= busy_d;
      err_q <= err_d;
      tx_write_q <= tx_write_d;
      tx_byte_q <= tx_byte_d;
      cmd_rw_q <= cmd_rw_d;
      cmd_id_q <= cmd_id_d;
      data_size_q <= data_size_d;
      cnt_q <= cnt_d;
      tmr_q <= tmr_d;
`ifdef MONITOR_CHECKSUM_EN
      csum_q <= csum_d;
`endif
    end
  end
endmodule

// File: doc/monitor_cmd_engine.md
MONITOR_CMD_ENGINE -- requirements
Module: monitor_cmd_engine

Interface
REQ-001 SHALL have parameter NUM_CMDS, default 16: number of addressable command registers; legal cmd_id range is 0..NUM_CMDS-1.
REQ-002 SHALL have parameter MAX_BYTES, default 8: maximum payload bytes per command, range 1..255.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: inter-byte receive timeout in clk50 cycles.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 Ports (name  direction  width  meaning):
- clk50  in  1  sole clock.
- reset_n  in  1  synchronous active-low reset.
- rx_valid  in  1  one-cycle pulse, rx_byte valid.
- rx_byte  in  8  received byte.
- rx_error  in  1  one-cycle pulse, parity/framing error.
- tx_ready  in  1  transmitter idle and able to accept a byte.
- tx_write  out  1  one-cycle pulse launching tx_byte.
- tx_byte  out  8  byte to transmit.
- uart_rts  in  1  controller request to send, active-low.
- uart_cts  out  1  clear to send, active-low.
- state  out  3  current FSM state encoding.
- cmd_rw  out  1  latched command bit 7 (1 = controller writes).
- cmd_id  out  7  latched command bits 6:0.
- data_size  out  8  latched payload length.
- reg_wr  out  1  one-cycle register byte write strobe.
- reg_sel  out  $clog2(NUM_CMDS)  register select (cmd_id truncated).
- reg_idx  out  $clog2(MAX_BYTES)  payload byte index.
- reg_wdata  out  8  byte to write.
- reg_rdata  in  8  combinational read data for reg_sel/reg_idx.
- busy  out  1  high in any state other than IDLE.
- err_flag  out  1  sticky error, cleared at next accepted command.

Function
REQ-006 SHALL implement states IDLE=0, READ_CMD=1, DATA_BYTES=2, WRITE=3, READ=4, RESP=5, ERROR=6.
REQ-007 IDLE: uart_rts low -> READ_CMD, uart_cts driven low next cycle, err_flag cleared; otherwise uart_cts high.
REQ-008 READ_CMD: on rx_valid latch cmd_rw/cmd_id -> DATA_BYTES; cmd_id >= NUM_CMDS -> ERROR.
REQ-009 DATA_BYTES: on rx_valid latch data_size; data_size > MAX_BYTES -> ERROR; data_size 0 -> RESP; else cmd_rw=1 -> WRITE, cmd_rw=0 -> READ (uart_cts high).
REQ-010 WRITE: each rx_valid drives reg_wr=1, reg_wdata=rx_byte, reg_idx=byte count, same cycle; after data_size bytes -> RESP.
REQ-011 READ: when tx_ready and no tx_write in previous cycle, pulse tx_write with tx_byte=reg_rdata, increment index; after data_size bytes -> IDLE.
REQ-012 RESP: when tx_ready, send ACK 0x06 once -> IDLE; ERROR: when tx_ready, send NAK 0x15 once, set err_flag -> IDLE.
REQ-013 Byte counter SHALL be 8 bits, reset to 0 on entry to WRITE/READ; reg_idx = low bits of counter.
REQ-014 Timeout counter SHALL reset on every rx_valid and on state change; reaching TIMEOUT_CYCLES in READ_CMD/DATA_BYTES/WRITE -> ERROR.
REQ-015 rx_error in READ_CMD/DATA_BYTES/WRITE -> ERROR, byte discarded; rx_valid and rx_error same cycle -> rx_error wins.
REQ-016 rx_valid in IDLE/READ/RESP/ERROR SHALL be ignored.
REQ-017 uart_cts SHALL be low only in READ_CMD, DATA_BYTES, WRITE.

Reset
REQ-018 reset_n low at a clk50 edge SHALL force, mid-transaction included: state IDLE, uart_cts 1, tx_write 0, reg_wr 0, tx_byte 0, cmd_rw 0, cmd_id 7'h7F, data_size 0, counters 0, err_flag 0, busy 0.

Configuration
REQ-019 Macro MONITOR_CHECKSUM_EN defined: WRITE expects one extra byte equal to XOR of payload, mismatch -> ERROR; READ appends XOR byte after payload; size-0 commands carry checksum 0x00.
REQ-020 MONITOR_CHECKSUM_EN undefined: no checksum byte in either direction, no checksum logic.

Verification
REQ-021 Write: rts low, bytes 0x83,0x02,0xAA,0x55 -> reg_wr at idx 0/1 on sel 3, ACK 0x06 sent, IDLE.
REQ-022 Read: bytes 0x05,0x03, reg_rdata 0x11,0x22,0x33 -> tx bytes 0x11,0x22,0x33, uart_cts high throughout READ.
REQ-023 Bad id: NUM_CMDS=16, cmd 0x90 -> NAK 0x15, err_flag 1, no reg_wr.
REQ-024 Timeout: TIMEOUT_CYCLES=100, stop after cmd byte -> ERROR at cycle 100, NAK sent.
REQ-025 Reset mid-WRITE after 1 of 4 bytes -> all outputs at REQ-018 values next cycle, next command accepted.
REQ-026 MONITOR_CHECKSUM_EN: write 0x81,0x02,0x0F,0xF0,0xFF -> ACK; checksum 0x00 -> NAK.
